// File: rtl/io_pkg.sv
// io_pkg -- shared constants for the memory-mapped I/O controller.
//   * Register offsets within the I/O window (byte offsets, word aligned).
//   * Width of the window offset field (addr[WIN_W-1:0]).
//   * Active-low seven-segment table, bit6..0 = g..a, indexed by hex digit.
package io_pkg;

    localparam int WIN_W = 8;

    localparam logic [WIN_W-1:0] OFF_HEXVAL  = 8'h00;
    localparam logic [WIN_W-1:0] OFF_LEDVAL  = 8'h04;
    localparam logic [WIN_W-1:0] OFF_KEYDATA = 8'h10;
    localparam logic [WIN_W-1:0] OFF_KEYCTL  = 8'h14;
    localparam logic [WIN_W-1:0] OFF_SWDATA  = 8'h20;
    localparam logic [WIN_W-1:0] OFF_TCNT    = 8'h30;
    localparam logic [WIN_W-1:0] OFF_TLIM    = 8'h34;
    localparam logic [WIN_W-1:0] OFF_TCTL    = 8'h38;

    // Entry 0 sits in the lowest slice, so SEG_TABLE[d] is the pattern for digit d.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_digit_decoder.sv
// hex_digit_decoder -- combinational 0-F to seven-segment decoder.
// Ports:
//   digit  in  4  hex value to display
//   seg    out 7  active-low segments, bit6..0 = g..a
module hex_digit_decoder
    import io_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/io_controller.sv
// io_controller -- memory-mapped I/O between the core data port and the DE-board pins.
// Ports:
//   CLOCK_50      in  1   system clock, all state on its rising edge
//   FPGA_RESET_N  in  1   synchronous reset, active-high
//   addr          in  32  byte address (addr[1:0] ignored)
//   wdata         in  32  write data
//   we / re       in  1   write / read strobes
//   rdata         out 32  registered read data, holds when re = 0
//   SW            in  10  raw switches (asynchronous)
//   KEY           in  4   raw pushbuttons, active-low (asynchronous)
//   LEDR          out 10  LED drive
//   HEX0..HEX5    out 7   active-low segment drive, bit6..0 = g..a
module io_controller
    import io_pkg::*;
#(
    parameter int          TICK_DIV = 50000,
    parameter logic [31:0] IO_BASE  = 32'hF000_0000
) (
    input  logic        CLOCK_50,
    input  logic        FPGA_RESET_N,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [9:0]  SW,
    input  logic [3:0]  KEY,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [23:0]    hex_val;
    logic [9:0]     led_val;
    logic [3:0]     key_p0, key_p1, key_p2;
    logic [9:0]     sw_p0, sw_p1;
    logic [3:0]     key_flag;
    logic [PW-1:0]  presc;
    logic [31:0]    tcnt, tlim;
    logic           expired;
    logic [31:0]    rd_mux;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr[1:0];

    // Bus decode: window match on the upper bits, word offset in the low byte.
    logic             in_win;
    logic [WIN_W-1:0] off;
    assign in_win = (addr[31:WIN_W] == IO_BASE[31:WIN_W]);
    assign off    = {addr[WIN_W-1:2], 2'b00};

    logic wr_hex, wr_led, wr_keyctl, wr_tlim, wr_tctl;
    assign wr_hex    = we && in_win && (off == OFF_HEXVAL);
    assign wr_led    = we && in_win && (off == OFF_LEDVAL);
    assign wr_keyctl = we && in_win && (off == OFF_KEYCTL);
    assign wr_tlim   = we && in_win && (off == OFF_TLIM);
    assign wr_tctl   = we && in_win && (off == OFF_TCTL);

    // Press detect on the synchronised, inverted KEY: rising edge of key_p1.
    logic [3:0] key_set;
    assign key_set = key_p1 & ~key_p2;

    // Timer tick: prescaler wrap while enabled; expiry when the count reaches TLIM-1.
    // A TLIM write restarts everything, so it suppresses the tick in that cycle.
    logic presc_wrap, tick, tmr_set;
    assign presc_wrap = (presc == PW'(TICK_DIV - 1));
    assign tick       = presc_wrap && (tlim != 32'd0) && !wr_tlim;
    assign tmr_set    = tick && (tcnt == tlim - 32'd1);

    always_comb begin
        rd_mux = 32'd0;
        if (in_win) begin
            case (off)
                OFF_HEXVAL:  rd_mux = {8'd0, hex_val};
                OFF_LEDVAL:  rd_mux = {22'd0, led_val};
                OFF_KEYDATA: rd_mux = {28'd0, key_p1};
                OFF_KEYCTL:  rd_mux = {28'd0, key_flag};
                OFF_SWDATA:  rd_mux = {22'd0, sw_p1};
                OFF_TCNT:    rd_mux = tcnt;
                OFF_TLIM:    rd_mux = tlim;
                OFF_TCTL:    rd_mux = {31'd0, expired};
                default:     rd_mux = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (FPGA_RESET_N) begin
            hex_val  <= '0;
            led_val  <= '0;
            key_p0   <= '0;
            key_p1   <= '0;
            key_p2   <= '0;
            sw_p0    <= '0;
            sw_p1    <= '0;
            key_flag <= '0;
            presc    <= '0;
            tcnt     <= '0;
            tlim     <= '0;
            expired  <= 1'b0;
            rdata    <= '0;
        end else begin
            // Synchroniser stage 0 -> 1, plus edge-detect history in key_p2
            key_p0 <= ~KEY;
            key_p1 <= key_p0;
            key_p2 <= key_p1;
            sw_p0  <= SW;
            sw_p1  <= sw_p0;

            if (wr_hex) hex_val <= wdata[23:0];
            if (wr_led) led_val <= wdata[9:0];

            // Set dominates a coincident write-1-to-clear.
            key_flag <= (key_flag & ~(wr_keyctl ? wdata[3:0] : 4'd0)) | key_set;
            expired  <= (expired & ~(wr_tctl & wdata[0])) | tmr_set;

            presc <= (wr_tlim || presc_wrap) ? '0 : presc + PW'(1);
            if (wr_tlim) begin
                tlim <= wdata;
                tcnt <= '0;
            end else if (tick) begin
                tcnt <= tmr_set ? 32'd0 : tcnt + 32'd1;
            end

            // Read stage: old register contents are captured, so read-during-write sees the old value.
            if (re) rdata <= rd_mux;
        end
    end

    assign LEDR = led_val;

    hex_digit_decoder u_hex0 (.digit(hex_val[3:0]),   .seg(HEX0));
    hex_digit_decoder u_hex1 (.digit(hex_val[7:4]),   .seg(HEX1));
    hex_digit_decoder u_hex2 (.digit(hex_val[11:8]),  .seg(HEX2));
    hex_digit_decoder u_hex3 (.digit(hex_val[15:12]), .seg(HEX3));
    hex_digit_decoder u_hex4 (.digit(hex_val[19:16]), .seg(HEX4));
    hex_digit_decoder u_hex5 (.digit(hex_val[23:20]), .seg(HEX5));

endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller -- directed stimulus with a read-data scoreboard for io_controller.
module tb_io_controller;

    localparam logic [31:0] BASE = 32'hF000_0000;

    logic        CLOCK_50 = 1'b0;
    logic        FPGA_RESET_N = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic [9:0]  SW = '0;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    io_controller #(.TICK_DIV(4), .IO_BASE(BASE)) dut (
        .CLOCK_50(CLOCK_50), .FPGA_RESET_N(FPGA_RESET_N),
        .addr(addr), .wdata(wdata), .we(we), .re(re), .rdata(rdata),
        .SW(SW), .KEY(KEY), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge CLOCK_50);
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        sb.push_back(e);
        last_rd = exp;
        addr = a; re = 1'b1;
        @(negedge CLOCK_50);
        re = 1'b0;
    endtask

    // Monitor: a read sampled on a rising edge is compared on the following falling edge.
    initial begin
        forever begin
            @(posedge CLOCK_50);
            if (re && !FPGA_RESET_N) begin
                @(negedge CLOCK_50);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: got %h, expected nothing queued", rdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check(e.name, rdata, e.val);
                end
            end
        end
    end

    task automatic check_hex(input string name, input logic [41:0] exp);
        check(name, {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'd0, exp});
    endtask

    initial begin
        // Reset held for two cycles
        cyc(2);
        FPGA_RESET_N = 1'b0;
        cyc(1);
        check_hex("reset_hex", {6{7'h40}});
        check("reset_ledr", {22'd0, LEDR}, 32'd0);
        check("reset_rdata", rdata, 32'd0);

        // HEX display
        wr(BASE + 32'h00, 32'h0012_AB0F);
        check_hex("hex_12AB0F", {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E});
        rd(BASE + 32'h00, 32'h0012_AB0F, "rd_hexval");

        // KEY press flag
        KEY = 4'b1011;
        cyc(4);
        rd(BASE + 32'h10, 32'h4, "rd_keydata");
        rd(BASE + 32'h14, 32'h4, "rd_keyctl_set");
        wr(BASE + 32'h14, 32'h4);
        rd(BASE + 32'h14, 32'h0, "rd_keyctl_clr");
        KEY = 4'b1111;
        cyc(4);
        rd(BASE + 32'h10, 32'h0, "rd_keydata_rel");
        // Press lands on the same edge as a W1C of that flag
        KEY = 4'b1011;
        cyc(2);
        wr(BASE + 32'h14, 32'h4);
        rd(BASE + 32'h14, 32'h4, "rd_keyctl_race");
        KEY = 4'b1111;

        // Timer: TICK_DIV = 4, TLIM = 3 -> expiry 12 edges after the write edge
        wr(BASE + 32'h34, 32'd3);
        cyc(11);
        rd(BASE + 32'h38, 32'h0, "tctl_edge12_old");
        rd(BASE + 32'h38, 32'h1, "tctl_edge13");
        rd(BASE + 32'h30, 32'd0, "tcnt_after_exp");
        cyc(2);
        rd(BASE + 32'h30, 32'd1, "tcnt_1");
        cyc(3);
        rd(BASE + 32'h30, 32'd2, "tcnt_2");
        cyc(3);
        rd(BASE + 32'h30, 32'd0, "tcnt_wrap");
        rd(BASE + 32'h34, 32'd3, "rd_tlim");
        wr(BASE + 32'h34, 32'd0);
        wr(BASE + 32'h38, 32'h1);
        rd(BASE + 32'h38, 32'h0, "tctl_clr");
        cyc(9);
        rd(BASE + 32'h30, 32'd0, "tcnt_disabled");

        // LEDs and address decode
        wr(BASE + 32'h04, 32'h3FF);
        check("ledr_3ff", {22'd0, LEDR}, 32'h3FF);
        rd(BASE + 32'hFC, 32'h0, "rd_unmapped");
        wr(32'h0000_0004, 32'h0);
        check("ledr_outside_win", {22'd0, LEDR}, 32'h3FF);
        rd(32'h0000_0004, 32'h0, "rd_outside_win");

        // Read-during-write returns the old value
        addr = BASE + 32'h04; wdata = 32'h0AA; we = 1'b1; re = 1'b1;
        begin
            exp_t e;
            e.name = "rdw_old";
            e.val  = 32'h3FF;
            sb.push_back(e);
        end
        @(negedge CLOCK_50);
        we = 1'b0; re = 1'b0;
        rd(BASE + 32'h04, 32'h0AA, "rd_ledval_new");
        cyc(3);
        check("rdata_hold", rdata, last_rd);

        // Switches
        SW = 10'h155;
        cyc(2);
        rd(BASE + 32'h20, 32'h155, "rd_swdata");

        // Reset mid-operation drops all state, including a pending flag
        KEY = 4'b1110;
        cyc(4);
        FPGA_RESET_N = 1'b1;
        cyc(1);
        FPGA_RESET_N = 1'b0;
        check_hex("midreset_hex", {6{7'h40}});
        check("midreset_ledr", {22'd0, LEDR}, 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        KEY = 4'b1111;
        cyc(1);
        rd(BASE + 32'h14, 32'h0, "rd_keyctl_after_rst");

        cyc(3);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL timeout: got no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

endmodule
